// File: rtl/joy_pkg.sv
// Shared joystick definitions: direction codes, button bits, FSM states.
// The downstream position tracker imports the same direction codes.
package joy_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_N     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } joy_state_t;

    // True only when exactly one line is pressed.
    function automatic logic is_single(input logic [BTN_N-1:0] b);
        return (b != '0) && ((b & (b - 4'd1)) == '0);
    endfunction

    function automatic logic [1:0] btn_to_dir(input logic [BTN_N-1:0] b);
        logic [1:0] d;
        d = DIR_UP;
        case (b)
            4'b0001: d = DIR_UP;
            4'b0010: d = DIR_DOWN;
            4'b0100: d = DIR_LEFT;
            4'b1000: d = DIR_RIGHT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/joy_dir_encoder_debounce_bit.sv
// One switch line: 2-flop synchroniser followed by a debounce counter.
// The clean level flips only after the synced level differs for DEBOUNCE_CYCLES.
module debounce_bit
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_clean
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_clean;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clean <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync == r_clean) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
            r_clean <= r_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_clean = r_clean;

endmodule

// File: rtl/joy_dir_encoder.sv
// Joystick input conditioner: debounce, one-hot direction encode and
// auto-repeating step pulses for the position tracker.
module joy_dir_encoder
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic [1:0] positions,
    output logic       step,
    output logic       held,
    output logic [3:0] btn_clean
);

    localparam logic [CNT_W-1:0] LP_DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] LP_RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    logic [BTN_N-1:0] w_clean;
    logic             w_valid;
    logic [1:0]       w_dir;
    logic             w_dir_chg;
    logic             w_dly_done;
    logic             w_rate_done;

    joy_state_t       r_state;
    joy_state_t       w_state_nxt;
    logic             w_step_nxt;
    logic [1:0]       w_pos_nxt;
    logic             w_timer_clr;

    logic [CNT_W-1:0] r_timer;
    logic             r_step;
    logic [1:0]       r_pos;
    logic             r_held;

    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (btn_raw[gi]),
            .o_clean(w_clean[gi])
        );
    end

    // r_pos always holds the direction being repeated outside IDLE.
    assign w_valid     = is_single(w_clean);
    assign w_dir       = btn_to_dir(w_clean);
    assign w_dir_chg   = (w_dir != r_pos);
    assign w_dly_done  = (r_timer == LP_DLY_LAST);
    assign w_rate_done = (r_timer == LP_RATE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) w_state_nxt = ST_DELAY;
            end
            ST_DELAY: begin
                if (!w_valid)       w_state_nxt = ST_IDLE;
                else if (w_dir_chg) w_state_nxt = ST_DELAY;
                else if (w_dly_done) w_state_nxt = ST_REPEAT;
            end
            ST_REPEAT: begin
                if (!w_valid)       w_state_nxt = ST_IDLE;
                else if (w_dir_chg) w_state_nxt = ST_DELAY;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_step_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE:   w_step_nxt = w_valid;
            ST_DELAY:  w_step_nxt = w_valid && (w_dir_chg || w_dly_done);
            ST_REPEAT: w_step_nxt = w_valid && (w_dir_chg || w_rate_done);
            default:   w_step_nxt = 1'b0;
        endcase
        w_pos_nxt = w_step_nxt ? w_dir : r_pos;
    end

    assign w_timer_clr = (w_state_nxt != r_state) || w_step_nxt ||
                         (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step <= 1'b0;
            r_pos  <= DIR_UP;
            r_held <= 1'b0;
        end else begin
            r_step <= w_step_nxt;
            r_pos  <= w_pos_nxt;
            r_held <= (w_state_nxt != ST_IDLE);
        end
    end

    assign positions = r_pos;
    assign step      = r_step;
    assign held      = r_held;
    assign btn_clean = w_clean;

endmodule

// File: tb/tb_joy_dir_encoder.sv
// Bench for joy_dir_encoder: deadline-based reference model checked every
// cycle, plus directed scenarios with hand-counted step latencies.
module tb_joy_dir_encoder;
    import joy_pkg::*;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [1:0] positions;
    logic       step;
    logic       held;
    logic [3:0] btn_clean;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    joy_dir_encoder #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .positions(positions),
        .step     (step),
        .held     (held),
        .btn_clean(btn_clean)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: lines flip after D consecutive differing synced samples; a held
    // direction steps at press, then at deadlines press+RD, +RR, +RR ...
    typedef struct packed {
        logic [3:0]      s1;
        logic [3:0]      s2;
        logic [3:0]      clean;
        logic [3:0][7:0] run;
        logic            act;
        logic            stp;
        logic [1:0]      pos;
        int              now;
        int              due;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mstep(mdl_t c, logic [3:0] raw);
        mdl_t n;
        int   ones;
        logic [1:0] d;
        n     = c;
        n.now = c.now + 1;
        ones  = 0;
        d     = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (c.clean[i]) begin
                ones++;
                d = 2'(i);
            end
        end
        n.stp = 1'b0;
        if (ones != 1) begin
            n.act = 1'b0;
        end else if (!c.act || d != c.pos) begin
            n.stp = 1'b1;
            n.pos = d;
            n.act = 1'b1;
            n.due = n.now + RD;
        end else if (n.now == c.due) begin
            n.stp = 1'b1;
            n.due = n.now + RR;
        end
        for (int i = 0; i < 4; i++) begin
            if (c.s2[i] == c.clean[i]) begin
                n.run[i] = 8'd0;
            end else if (int'(c.run[i]) + 1 == D) begin
                n.clean[i] = c.s2[i];
                n.run[i]   = 8'd0;
            end else begin
                n.run[i] = c.run[i] + 8'd1;
            end
        end
        n.s2 = c.s1;
        n.s1 = raw;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= mstep(m, btn_raw);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_step", int'(step), int'(m.stp));
            chk("mdl_pos", int'(positions), int'(m.pos));
            chk("mdl_held", int'(held), int'(m.act));
            chk("mdl_clean", int'(btn_clean), int'(m.clean));
        end
    end

    // Edge index (1-based) of the first step, 0 if none within max edges.
    task automatic wait_step(input int max, output int n);
        bit done;
        done = 0;
        n    = 0;
        for (int i = 1; i <= max && !done; i++) begin
            @(posedge clk);
            #1;
            if (step) begin
                n    = i;
                done = 1;
            end
        end
    endtask

    task automatic wait_pos_step(input int max, input logic [1:0] p,
                                 output int n);
        bit done;
        done = 0;
        n    = 0;
        for (int i = 1; i <= max && !done; i++) begin
            @(posedge clk);
            #1;
            if (step && positions == p) begin
                n    = i;
                done = 1;
            end
        end
    endtask

    task automatic wait_held_low(input int max, output int n);
        bit done;
        done = 0;
        n    = 0;
        for (int i = 1; i <= max && !done; i++) begin
            @(posedge clk);
            #1;
            if (!held) begin
                n    = i;
                done = 1;
            end
        end
    endtask

    task automatic count_steps(input int edges, output int k);
        k = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            if (step) k++;
        end
    endtask

    initial begin
        int n;
        int k;
        int kb;
        reset   = 1'b0;
        btn_raw = 4'b0000;

        // Async reset mid-cycle with idle lines
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_step", int'(step), 0);
        chk("rst_held", int'(held), 0);
        chk("rst_pos", int'(positions), 0);
        chk("rst_clean", int'(btn_clean), 0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1;
        count_steps(3, k);
        chk("post_rst_steps", k, 0);
        chk("post_rst_held", int'(held), 0);

        // Held up: steps at 7, 17, 20, 23
        btn_raw = 4'b0001;
        wait_step(20, n);
        chk("up_first", n, 7);
        chk("up_pos", int'(positions), int'(DIR_UP));
        chk("up_held", int'(held), 1);
        wait_step(20, n);
        chk("up_delay", n, RD);
        wait_step(20, n);
        chk("up_rate1", n, RR);
        wait_step(20, n);
        chk("up_rate2", n, RR);
        btn_raw = 4'b0000;
        wait_held_low(20, n);
        chk("up_release", n, 7);
        count_steps(10, k);
        chk("up_idle_steps", k, 0);
        chk("up_pos_kept", int'(positions), int'(DIR_UP));

        // Bounce on right, then settle high
        kb = 0;
        for (int i = 0; i < 10; i++) begin
            btn_raw[3] = ~btn_raw[3];
            count_steps(2, k);
            kb += k;
        end
        chk("bounce_steps", kb, 0);
        chk("bounce_clean", int'(btn_clean), 0);
        btn_raw = 4'b1000;
        wait_step(20, n);
        chk("bounce_settle", n, 7);
        chk("bounce_pos", int'(positions), int'(DIR_RIGHT));
        count_steps(5, k);
        chk("bounce_single", k, 0);
        btn_raw = 4'b0000;
        count_steps(20, k);

        // Multi-press, then release one line
        btn_raw = 4'b0101;
        count_steps(10, k);
        chk("multi_steps", k, 0);
        chk("multi_clean", int'(btn_clean), 5);
        chk("multi_held", int'(held), 0);
        btn_raw = 4'b0100;
        wait_step(20, n);
        chk("multi_release", n, 7);
        chk("multi_pos", int'(positions), int'(DIR_LEFT));
        btn_raw = 4'b0000;
        count_steps(20, k);

        // Down into REPEAT, then switch to right
        btn_raw = 4'b0010;
        wait_step(20, n);
        chk("down_first", n, 7);
        wait_step(20, n);
        chk("down_delay", n, RD);
        chk("down_pos", int'(positions), int'(DIR_DOWN));
        btn_raw = 4'b1000;
        wait_pos_step(20, DIR_RIGHT, n);
        chk("chg_latency", n, 7);
        wait_step(20, n);
        chk("chg_delay", n, RD);
        chk("chg_pos", int'(positions), int'(DIR_RIGHT));
        wait_step(20, n);
        chk("chg_rate", n, RR);

        // Reset in REPEAT on the step cycle, right still held
        #2 reset = 1'b1;
        #1;
        chk("rst2_step", int'(step), 0);
        chk("rst2_held", int'(held), 0);
        chk("rst2_pos", int'(positions), 0);
        chk("rst2_clean", int'(btn_clean), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        wait_step(20, n);
        chk("rst2_first", n, 7);
        chk("rst2_pos_after", int'(positions), int'(DIR_RIGHT));
        btn_raw = 4'b0000;
        count_steps(20, k);
        chk("final_held", int'(held), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
